// File: rtl/wdt_timer_if.sv
// Watchdog register-side bundle between the AXI wrapper and the countdown core.
// Latency: none, plain wires; the core registers everything it drives back.
// Backpressure: none, level signals only; WDLIVE kicks are edge-detected by the core.
interface wdt_timer_if #(
  parameter int CNT_W = 32
);
  logic             WDEN;
  logic             WDLIVE;
  logic [CNT_W-1:0] WTOCNT;
  logic             WTO;
  logic [CNT_W-1:0] WDT_CNT;
  logic [1:0]       WDT_STATE;

  // Wrapper side: drives the control registers, observes timeout and readback.
  modport master (
    output WDEN,
    output WDLIVE,
    output WTOCNT,
    input  WTO,
    input  WDT_CNT,
    input  WDT_STATE
  );

  // Core side: consumes the control registers, drives timeout and readback.
  modport slave (
    input  WDEN,
    input  WDLIVE,
    input  WTOCNT,
    output WTO,
    output WDT_CNT,
    output WDT_STATE
  );
endinterface

// File: rtl/wdt_timer.sv
// Watchdog countdown core: prescaled tick counter, WDLIVE rising-edge kick, sticky WTO.
// Latency: WTO rises (WTOCNT+1)*PRESCALE edges after the enabling edge unless kicked.
// Backpressure: none; WDEN/WDLIVE/WTOCNT are sampled every edge, outputs are registered.
module wdt_timer #(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 32
) (
  input logic        clk,
  input logic        rst,
  wdt_timer_if.slave wdt
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    COUNTING = 2'd1,
    EXPIRED  = 2'd2
  } state_t;

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] timeout_q, timeout_nxt;
  logic [PW-1:0]    presc_q, presc_nxt;
  logic             wto_q, wto_nxt;
  logic             wdlive_d;
  logic             tick;
  logic             kick;

  // State, counters, latched timeout and the WDLIVE history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DISABLED;
      cnt_q     <= '0;
      timeout_q <= '0;
      presc_q   <= '0;
      wto_q     <= 1'b0;
      wdlive_d  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      timeout_q <= timeout_nxt;
      presc_q   <= presc_nxt;
      wto_q     <= wto_nxt;
      wdlive_d  <= wdt.WDLIVE;
    end
  end

  // Next-state logic; kick beats expiry, and cnt stops at timeout_q so it never wraps.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    timeout_nxt = timeout_q;
    presc_nxt   = presc_q;
    tick        = (presc_q == PRE_MAX);
    kick        = wdt.WDLIVE & ~wdlive_d;

    case (state_q)
      DISABLED: begin
        cnt_nxt   = '0;
        presc_nxt = '0;
        if (wdt.WDEN) begin
          state_nxt   = COUNTING;
          timeout_nxt = wdt.WTOCNT;
        end
      end
      COUNTING: begin
        if (!wdt.WDEN) begin
          state_nxt = DISABLED;
          cnt_nxt   = '0;
          presc_nxt = '0;
        end else if (kick) begin
          cnt_nxt     = '0;
          presc_nxt   = '0;
          timeout_nxt = wdt.WTOCNT;
        end else begin
          presc_nxt = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (cnt_q == timeout_q) begin
              state_nxt = EXPIRED;
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      EXPIRED: begin
        // Frozen until software drops the enable; kicks are ignored here.
        if (!wdt.WDEN) begin
          state_nxt = DISABLED;
          cnt_nxt   = '0;
          presc_nxt = '0;
        end
      end
      default: begin
        state_nxt = DISABLED;
        cnt_nxt   = '0;
        presc_nxt = '0;
      end
    endcase

    wto_nxt = (state_nxt == EXPIRED);
  end

  assign wdt.WTO       = wto_q;
  assign wdt.WDT_CNT   = cnt_q;
  assign wdt.WDT_STATE = state_q;

endmodule

// File: tb/tb_wdt_timer.sv
// Directed bench for wdt_timer with PRESCALE=1 and PRESCALE=4 instances.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: none; every step is a fixed number of clock edges.
module tb_wdt_timer;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wdt_timer_if #(.CNT_W(CNT_W)) bus1 ();
  wdt_timer_if #(.CNT_W(CNT_W)) bus4 ();

  wdt_timer #(.PRESCALE(1), .CNT_W(CNT_W)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .wdt (bus1)
  );

  wdt_timer #(.PRESCALE(4), .CNT_W(CNT_W)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .wdt (bus4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int exp_cnt4 [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2};

    rst         = 1'b1;
    bus1.WDEN   = 1'b0;
    bus1.WDLIVE = 1'b0;
    bus1.WTOCNT = '0;
    bus4.WDEN   = 1'b0;
    bus4.WDLIVE = 1'b0;
    bus4.WTOCNT = '0;

    // Reset state
    #1;
    chk("rst_state1", bus1.WDT_STATE, 0);
    chk("rst_cnt1",   bus1.WDT_CNT, 0);
    chk("rst_wto1",   bus1.WTO, 0);
    chk("rst_state4", bus4.WDT_STATE, 0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("idle_state", bus1.WDT_STATE, 0);

    // Basic countdown, T=3, P=1
    bus1.WTOCNT = 3;
    bus1.WDEN   = 1'b1;
    step(1);
    chk("en_state", bus1.WDT_STATE, 1);
    chk("en_cnt",   bus1.WDT_CNT, 0);
    step(1); chk("cnt_e1", bus1.WDT_CNT, 1);
    step(1); chk("cnt_e2", bus1.WDT_CNT, 2);
    step(1); chk("cnt_e3", bus1.WDT_CNT, 3);
    chk("wto_e3", bus1.WTO, 0);
    step(1);
    chk("wto_e4",   bus1.WTO, 1);
    chk("state_e4", bus1.WDT_STATE, 2);
    chk("cnt_e4",   bus1.WDT_CNT, 3);

    // Kicks ignored while expired, then disable and re-enable
    bus1.WDLIVE = 1'b1; step(1);
    chk("exp_kick_wto", bus1.WTO, 1);
    chk("exp_kick_cnt", bus1.WDT_CNT, 3);
    bus1.WDLIVE = 1'b0; step(1);
    bus1.WDLIVE = 1'b1; step(1);
    chk("exp_kick2_wto", bus1.WTO, 1);
    bus1.WDLIVE = 1'b0;
    bus1.WDEN   = 1'b0;
    step(1);
    chk("dis_wto",   bus1.WTO, 0);
    chk("dis_state", bus1.WDT_STATE, 0);
    chk("dis_cnt",   bus1.WDT_CNT, 0);
    bus1.WDEN = 1'b1;
    step(1);
    chk("reen_state", bus1.WDT_STATE, 1);
    chk("reen_cnt0",  bus1.WDT_CNT, 0);
    step(1);
    chk("reen_cnt1", bus1.WDT_CNT, 1);
    bus1.WDEN = 1'b0;
    step(1);

    // T=0 expires one tick after enable
    bus1.WTOCNT = 0;
    bus1.WDEN   = 1'b1;
    step(1);
    chk("t0_wto_e0", bus1.WTO, 0);
    step(1);
    chk("t0_wto_e1",   bus1.WTO, 1);
    chk("t0_state_e1", bus1.WDT_STATE, 2);
    bus1.WDEN = 1'b0;
    step(1);

    // Kick with a new timeout, T=5 then T=1
    bus1.WTOCNT = 5;
    bus1.WDEN   = 1'b1;
    step(1);
    step(2);
    chk("k_cnt_e2", bus1.WDT_CNT, 2);
    bus1.WDLIVE = 1'b1;
    bus1.WTOCNT = 1;
    step(1);
    chk("k_cnt_e3",   bus1.WDT_CNT, 0);
    chk("k_state_e3", bus1.WDT_STATE, 1);
    bus1.WDLIVE = 1'b0;
    step(1);
    chk("k_cnt_e4", bus1.WDT_CNT, 1);
    chk("k_wto_e4", bus1.WTO, 0);
    step(1);
    chk("k_wto_e5", bus1.WTO, 1);
    bus1.WDEN = 1'b0;
    step(1);

    // Kick and expiry on the same edge; held WDLIVE does not re-kick
    bus1.WTOCNT = 2;
    bus1.WDEN   = 1'b1;
    step(1);
    step(2);
    bus1.WDLIVE = 1'b1;
    step(1);
    chk("ke_wto_e3", bus1.WTO, 0);
    chk("ke_cnt_e3", bus1.WDT_CNT, 0);
    step(2);
    chk("ke_cnt_e5", bus1.WDT_CNT, 2);
    chk("ke_wto_e5", bus1.WTO, 0);
    step(1);
    chk("ke_wto_e6", bus1.WTO, 1);
    bus1.WDLIVE = 1'b0;
    bus1.WDEN   = 1'b0;
    step(1);

    // PRESCALE=4, T=2: expiry exactly 12 edges after enable
    bus4.WTOCNT = 2;
    bus4.WDEN   = 1'b1;
    step(1);
    chk("p4_state_e0", bus4.WDT_STATE, 1);
    for (int e = 1; e <= 12; e++) begin
      step(1);
      chk($sformatf("p4_cnt_e%0d", e), bus4.WDT_CNT, exp_cnt4[e-1]);
      chk($sformatf("p4_wto_e%0d", e), bus4.WTO, (e == 12) ? 1 : 0);
    end
    bus4.WDEN = 1'b0;
    step(1);
    chk("p4_dis_wto", bus4.WTO, 0);

    // Asynchronous reset mid-count, then restart with WDEN held high
    bus1.WTOCNT = 20;
    bus1.WDEN   = 1'b1;
    step(1);
    step(7);
    chk("ar_cnt7", bus1.WDT_CNT, 7);
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt",   bus1.WDT_CNT, 0);
    chk("ar_wto",   bus1.WTO, 0);
    chk("ar_state", bus1.WDT_STATE, 0);
    #1 rst = 1'b0;
    step(1);
    chk("ar_restart_state", bus1.WDT_STATE, 1);
    chk("ar_restart_cnt0",  bus1.WDT_CNT, 0);
    step(1);
    chk("ar_restart_cnt1", bus1.WDT_CNT, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
